// File: rtl/bpsk_phase_generator.sv
// BPSK phase generator: turns a handshaked serial bit stream into a per-clock
// sine-table phase index, flipping the carrier by half a period for '1' bits.
module bpsk_phase_generator #(
  parameter int unsigned DATA_WIDTH        = 8,
  parameter int unsigned SINE_RESOLUTION   = 64,
  parameter int unsigned PHASE_STEP        = 4,
  parameter int unsigned CYCLES_PER_SYMBOL = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  bit_in,
  input  logic                  bit_valid,
  output logic                  bit_ready,
  output logic [DATA_WIDTH-1:0] phase,
  output logic                  phase_valid,
  output logic                  symbol_start
);

  localparam int unsigned PERIOD = 2 * SINE_RESOLUTION;
  localparam int unsigned ACC_W  = DATA_WIDTH + 1;
  localparam int unsigned CYC_W  = (CYCLES_PER_SYMBOL > 1) ? $clog2(CYCLES_PER_SYMBOL) : 1;

  localparam logic [ACC_W-1:0] PERIOD_A  = ACC_W'(PERIOD);
  localparam logic [ACC_W-1:0] STEP_A    = ACC_W'(PHASE_STEP);
  localparam logic [ACC_W-1:0] HALF_A    = ACC_W'(SINE_RESOLUTION);
  localparam logic [ACC_W-1:0] BASE_LAST = ACC_W'(PERIOD - PHASE_STEP);
  localparam logic [CYC_W-1:0] CYC_LAST  = CYC_W'(CYCLES_PER_SYMBOL - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [ACC_W-1:0]      r_base;
  logic [CYC_W-1:0]      r_cyc;
  logic                  r_cur_bit;
  logic [DATA_WIDTH-1:0] r_phase;
  logic                  r_phase_valid;
  logic                  r_symbol_start;

  logic [ACC_W-1:0]      w_base_nxt;
  logic [CYC_W-1:0]      w_cyc_nxt;
  logic                  w_cur_bit_nxt;
  logic [DATA_WIDTH-1:0] w_phase_nxt;
  logic                  w_phase_valid_nxt;
  logic                  w_symbol_start_nxt;

  logic                  w_last;
  logic                  w_accept;
  logic [ACC_W-1:0]      w_base_inc;
  logic                  w_wrap;
  logic [ACC_W-1:0]      w_base_adv;
  logic [ACC_W-1:0]      w_sum;
  logic [ACC_W-1:0]      w_phase_adv;

  // Carrier advance and offset, all in one extra bit so the modulo never depends on overflow
  assign w_last      = (r_state == S_RUN) && (r_cyc == CYC_LAST) && (r_base == BASE_LAST);
  assign w_accept    = bit_valid && bit_ready;
  assign w_base_inc  = r_base + STEP_A;
  assign w_wrap      = (w_base_inc >= PERIOD_A);
  assign w_base_adv  = w_wrap ? (w_base_inc - PERIOD_A) : w_base_inc;
  assign w_sum       = w_base_adv + (r_cur_bit ? HALF_A : '0);
  assign w_phase_adv = (w_sum >= PERIOD_A) ? (w_sum - PERIOD_A) : w_sum;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = S_IDLE;
    if (w_accept) begin
      w_state_nxt = S_RUN;
    end else if ((r_state == S_RUN) && !w_last) begin
      w_state_nxt = S_RUN;
    end
  end

  // Output and datapath next values; idle and end-of-stream fall through to the cleared defaults
  always_comb begin
    bit_ready          = (r_state == S_IDLE) || w_last;
    w_base_nxt         = '0;
    w_cyc_nxt          = '0;
    w_cur_bit_nxt      = 1'b0;
    w_phase_nxt        = '0;
    w_phase_valid_nxt  = 1'b0;
    w_symbol_start_nxt = 1'b0;
    if (w_accept) begin
      w_cur_bit_nxt      = bit_in;
      w_phase_nxt        = bit_in ? DATA_WIDTH'(SINE_RESOLUTION) : '0;
      w_phase_valid_nxt  = 1'b1;
      w_symbol_start_nxt = 1'b1;
    end else if ((r_state == S_RUN) && !w_last) begin
      w_base_nxt        = w_base_adv;
      w_cyc_nxt         = w_wrap ? (r_cyc + CYC_W'(1)) : r_cyc;
      w_cur_bit_nxt     = r_cur_bit;
      w_phase_nxt       = DATA_WIDTH'(w_phase_adv);
      w_phase_valid_nxt = 1'b1;
    end
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_base         <= '0;
      r_cyc          <= '0;
      r_cur_bit      <= 1'b0;
      r_phase        <= '0;
      r_phase_valid  <= 1'b0;
      r_symbol_start <= 1'b0;
    end else begin
      r_base         <= w_base_nxt;
      r_cyc          <= w_cyc_nxt;
      r_cur_bit      <= w_cur_bit_nxt;
      r_phase        <= w_phase_nxt;
      r_phase_valid  <= w_phase_valid_nxt;
      r_symbol_start <= w_symbol_start_nxt;
    end
  end

  assign phase        = r_phase;
  assign phase_valid  = r_phase_valid;
  assign symbol_start = r_symbol_start;

endmodule
